wrapper_packet_digest_filter: RTL

- Parametrised successor to the single-packet digest valid filter in the accelerator wrapper.
- Snoops the AXI-Stream input handshake and records the block count of each packet in a FIFO, so several packets can be in flight at once.
- Counts digest events from the hash core and forwards digests to a registered valid/ready output. Forwarding is either final-digest-only or every digest tagged with a last flag.
- Sits between the hash core digest output and the wrapper output packetiser.

---
 rtl/wrapper_packet_digest_filter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/wrapper_packet_digest_filter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wrapper_packet_digest_filter: per-packet block counting and digest filter |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module wrapper_packet_digest_filter #(
  parameter int COUNT_W   = 16,
  parameter int PKT_DEPTH = 4,
  parameter int DIGEST_W  = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_tvalid_i,
  input  logic                          s_tready_i,
  input  logic                          s_tlast_i,
  input  logic                          digest_valid_i,
  input  logic [DIGEST_W-1:0]           digest_i,
  input  logic                          cfg_emit_all_i,
  output logic                          m_hash_valid_o,
  input  logic                          m_hash_ready_i,
  output logic [DIGEST_W-1:0]           m_hash_o,
  output logic                          m_hash_last_o,
  output logic [$clog2(PKT_DEPTH):0]    pkt_pending_o,
  output logic [2:0]                    err_o
);

  localparam int                  AW        = $clog2(PKT_DEPTH);
  localparam logic [COUNT_W-1:0]  c_cnt_max = '1;
  localparam logic [COUNT_W-1:0]  c_cnt_one = COUNT_W'(1);
  localparam logic [AW-1:0]       c_ptr_one = AW'(1);
  localparam logic [AW:0]         c_occ_one = (AW+1)'(1);
  localparam logic [AW:0]         c_depth   = (AW+1)'(PKT_DEPTH);

  logic [COUNT_W-1:0]  block_cnt_q, block_cnt_d;
  logic [COUNT_W-1:0]  digest_cnt_q, digest_cnt_d;
  logic [COUNT_W-1:0]  fifo_q [PKT_DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]         occ_q, occ_d;
  logic                prev_valid_q;
  logic [DIGEST_W-1:0] hash_q, hash_d;
  logic                last_q, last_d, valid_q, valid_d;
  logic [2:0]          err_q, err_d;

  logic                accept, push, push_ok, fifo_full, fifo_empty;
  logic                dig_event, is_final, pop, forward, overrun, load;
  logic [COUNT_W-1:0]  blk_inc, head;

  assign accept     = s_tvalid_i & s_tready_i;
  assign push       = accept & s_tlast_i;
  assign fifo_full  = (occ_q == c_depth);
  assign fifo_empty = (occ_q == '0);
  assign push_ok    = push & ~fifo_full;
  assign blk_inc    = (block_cnt_q == c_cnt_max) ? c_cnt_max : block_cnt_q + c_cnt_one;

  // Occupancy is registered, so a push is only seen by the digest side next cycle.
  assign dig_event  = digest_valid_i & ~prev_valid_q;
  assign head       = fifo_q[rd_ptr_q];
  assign is_final   = (digest_cnt_q == head - c_cnt_one);
  assign pop        = dig_event & ~fifo_empty & is_final;
  assign forward    = dig_event & ~fifo_empty & (is_final | cfg_emit_all_i);
  assign overrun    = forward & valid_q & ~m_hash_ready_i;
  assign load       = forward & ~overrun;

  always_comb begin
    block_cnt_d  = block_cnt_q;
    digest_cnt_d = digest_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    occ_d        = occ_q;
    hash_d       = hash_q;
    last_d       = last_q;
    valid_d      = valid_q;

    if (accept) block_cnt_d = s_tlast_i ? '0 : blk_inc;
    if (push_ok) wr_ptr_d = wr_ptr_q + c_ptr_one;
    if (pop) rd_ptr_d = rd_ptr_q + c_ptr_one;

    case ({push_ok, pop})
      2'b10:   occ_d = occ_q + c_occ_one;
      2'b01:   occ_d = occ_q - c_occ_one;
      default: occ_d = occ_q;
    endcase

    if (dig_event && !fifo_empty) digest_cnt_d = is_final ? '0 : digest_cnt_q + c_cnt_one;

    // A new load in the handshake cycle replaces the outgoing digest without a bubble.
    if (load) begin
      hash_d  = digest_i;
      last_d  = is_final;
      valid_d = 1'b1;
    end else if (valid_q && m_hash_ready_i) begin
      valid_d = 1'b0;
    end

    err_d = err_q | {overrun, dig_event & fifo_empty, push & fifo_full};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      block_cnt_q  <= '0;
      digest_cnt_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      prev_valid_q <= 1'b0;
      hash_q       <= '0;
      last_q       <= 1'b0;
      valid_q      <= 1'b0;
      err_q        <= '0;
    end else begin
      block_cnt_q  <= block_cnt_d;
      digest_cnt_q <= digest_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      prev_valid_q <= digest_valid_i;
      hash_q       <= hash_d;
      last_q       <= last_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
    end
  end

  // Entry storage needs no reset: the pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_ptr_q] <= blk_inc;
  end

  assign m_hash_valid_o = valid_q;
  assign m_hash_o       = hash_q;
  assign m_hash_last_o  = last_q;
  assign pkt_pending_o  = occ_q;
  assign err_o          = err_q;

endmodule
`default_nettype wire
